display_arbiter: RTL
====================

# display_arbiter

Sequencing and sharing controller for the 8-digit seven-segment display. Arbitrates between two requesters: CPU MMIO writes and the switch-echo path. The CPU value is held on screen for a programmable time, and the block generates the digit-scan schedule. Outputs one registered 32-bit display word, a per-digit enable mask and the active digit index, which feed the segment decoder/driver.

## Interface
- HOLD_CYCLES, 50_000_000: cycles a CPU-written value keeps ownership after its last write (≥2).
- SCAN_DIV, 50_000: cycles per digit slot in the scan (≥2).
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous active-low reset.
- cpu_we  in  1  single-cycle CPU display write strobe.
- cpu_data  in  32  CPU display word, sampled when cpu_we=1.
- sw_en  in  1  level; switch-echo mode requested.
- sw_data  in  16  switch value to echo.
- lz_blank  in  1  level; suppress leading-zero digits.
- cpu_ack  out  1  one-cycle pulse, the cycle after an accepted cpu_we.
- disp_value  out  32  word to display, nibble i → digit i.
- disp_owner  out  2  0 NONE, 1 CPU, 2 SW.
- digit_en  out  8  per-digit enable; 0 = digit dark.
- digit_sel  out  3  digit currently scanned.
- scan_tick  out  1  one-cycle pulse when digit_sel advances.

## Operation
- FSM states: IDLE, SHOW_CPU, SHOW_SW.
- Reset: state IDLE. disp_value=0, disp_owner=0, digit_en=0, digit_sel=0, scan_tick=0, cpu_ack=0. Hold and scan counters are 0.
- **IDLE**
  - cpu_we → SHOW_CPU. Latch cpu_data and load hold counter with HOLD_CYCLES-1.
  - Otherwise, sw_en → SHOW_SW.
  - disp_value retains its last contents. digit_en=0.
- **SHOW_CPU**
  - Every cpu_we reloads cpu_data and the hold counter, and pulses cpu_ack.
  - sw_en is ignored while the counter is nonzero.
  - Counter reaches 0 with no cpu_we that cycle → SHOW_SW if sw_en, else IDLE.
- **SHOW_SW**
  - disp_value = {16'h0000, sw_data}, re-registered every cycle.
  - cpu_we → SHOW_CPU (preemption).
  - sw_en low → IDLE.
- Simultaneous cpu_we and sw_en: CPU always wins.
- cpu_we is accepted in every state. No write is ever dropped. cpu_ack follows each accepted cpu_we.
- disp_owner encodes the state: IDLE=0, SHOW_CPU=1, SHOW_SW=2.
- **digit_en**
  - 0 in IDLE.
  - Otherwise, with lz_blank=0: 8'hFF.
  - With lz_blank=1: enable digits 0..k, where k is the index of the highest nonzero nibble of disp_value. Digit 0 is always enabled, so a zero value shows "0".
  - digit_en is computed from the registered disp_value and registered itself.
- **Scan**
  - Free-running in all states.
  - The scan counter counts 0..SCAN_DIV-1.
  - On wrap: scan_tick=1 for that cycle, and digit_sel increments modulo 8 (7→0).

## Timing
- cpu_we at cycle t:
  - t+1: disp_value=cpu_data, disp_owner=1, cpu_ack=1.
  - t+2: digit_en valid.
- Hold: with no further write, ownership is released at t+1+HOLD_CYCLES. The new owner/value is visible that cycle.
- SHOW_SW: sw_data→disp_value latency is 1 cycle; digit_en latency is 2 cycles.
- sw_en deassert at t: disp_owner=0 at t+1, digit_en=0 at t+1.
- scan_tick occurs every SCAN_DIV cycles. The first tick comes SCAN_DIV cycles after reset release. digit_sel changes in the same cycle as scan_tick.
- Reset asserted mid-hold or mid-scan: all outputs take their reset values immediately (asynchronous). Counters restart from 0 on release.
- Hold counter width: $clog2(HOLD_CYCLES). Scan counter width: $clog2(SCAN_DIV). Neither saturates nor underflows below 0.

## Structure
- Package disp_pkg:
  - owner encoding constants OWN_NONE/OWN_CPU/OWN_SW (2-bit)
  - FSM state typedef
  - NUM_DIGITS=8
- Sub-module disp_scan_timer: scan counter, scan_tick, digit_sel; parameter SCAN_DIV.
- FSM, hold counter and leading-zero logic stay in display_arbiter.

## Test plan
Parameters: HOLD_CYCLES=8, SCAN_DIV=4.
- **Reset:** release rst → all outputs 0. First scan_tick after 4 cycles. digit_sel goes 0→1→…→7→0 at ticks 1..8.
- **CPU hold:** cpu_we with 32'h1234_ABCD → next cycle owner=1, cpu_ack=1, value=32'h1234_ABCD. With sw_en=0, owner=0 eight cycles after ack and digit_en=0.
- **Rewrite extends hold:** cpu_we 32'h1, then cpu_we 32'h2 five cycles later → value=32'h2. Owner stays 1 until 8 cycles after the second ack.
- **Priority and preemption:**
  - cpu_we with sw_en=1 in the same cycle → owner=1.
  - After hold expiry → owner=2, value=32'h0000_00A5 for sw_data=16'h00A5.
  - cpu_we during SW → owner=1 next cycle.
- **Leading-zero blank:**
  - lz_blank=1, SW value 16'h00A5 → digit_en=8'h03.
  - Value 0 → 8'h01.
  - lz_blank=0 → 8'hFF.
- **Async reset mid-hold:** assert rst 3 cycles into a hold → outputs 0 in the same cycle. After release, sw_en=1 gives owner=2 with no CPU residue.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared encodings for the seven-segment display arbiter: owner codes,
// arbiter state type and the digit count of the display.
package disp_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_SW   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHOW_CPU = 2'd1,
    ST_SHOW_SW  = 2'd2
  } disp_state_t;

endpackage

// File: rtl/disp_scan_timer.sv
// Free-running digit scan timer: one slot every SCAN_DIV cycles, with a
// registered tick pulse and a digit index that advances on the same cycle.
module disp_scan_timer
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 50_000
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          scan_tick,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_sel
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          wrap;

  // Next-state: count 0..SCAN_DIV-1, pulse and advance the digit on wrap.
  always_comb begin
    wrap   = (cnt_q == CNT_MAX);
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    tick_d = wrap;
    sel_d  = wrap ? sel_q + SW'(1) : sel_q;
  end

  // Scan state registers; everything restarts from 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      sel_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      sel_q  <= sel_d;
    end
  end

  assign scan_tick = tick_q;
  assign digit_sel = sel_q;

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates the 8-digit display between CPU writes (held for HOLD_CYCLES
// after the last write) and the switch-echo path, computes the per-digit
// enable mask with optional leading-zero blanking and runs the scan timer.
module display_arbiter
  import disp_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int SCAN_DIV    = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic [31:0] cpu_data,
  input  logic        sw_en,
  input  logic [15:0] sw_data,
  input  logic        lz_blank,
  output logic        cpu_ack,
  output logic [31:0] disp_value,
  output logic [1:0]  disp_owner,
  output logic [7:0]  digit_en,
  output logic [2:0]  digit_sel,
  output logic        scan_tick
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  disp_state_t   state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [31:0]   value_q, value_d;
  logic [7:0]    digit_en_q, digit_en_d;
  logic          ack_q, ack_d;
  logic [7:0]    lz_mask;

  // Digit 0 always lit; digit gi lit when any nibble at or above it is nonzero.
  assign lz_mask[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
      assign lz_mask[gi] = |value_q[31:4*gi];
    end
  endgenerate

  // Ownership FSM, hold countdown and display word selection.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    value_d = value_q;
    ack_d   = cpu_we;
    case (state_q)
      ST_IDLE: begin
        if (cpu_we)     state_d = ST_SHOW_CPU;
        else if (sw_en) state_d = ST_SHOW_SW;
      end
      ST_SHOW_CPU: begin
        if (!cpu_we) begin
          if (hold_q == '0) state_d = sw_en ? ST_SHOW_SW : ST_IDLE;
          else              hold_d  = hold_q - HW'(1);
        end
      end
      ST_SHOW_SW: begin
        if (cpu_we)      state_d = ST_SHOW_CPU;
        else if (!sw_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A CPU write wins in every state and restarts the hold window.
    if (cpu_we) begin
      value_d = cpu_data;
      hold_d  = HOLD_LOAD;
    end else if (state_d == ST_SHOW_SW) begin
      value_d = {16'h0000, sw_data};
    end
    // Mask is derived from the word already on screen, so it trails by a cycle;
    // going idle darkens the display on the same cycle ownership drops.
    if (state_d == ST_IDLE) digit_en_d = 8'h00;
    else if (lz_blank)      digit_en_d = lz_mask;
    else                    digit_en_d = 8'hFF;
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      value_q    <= '0;
      digit_en_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      value_q    <= value_d;
      digit_en_q <= digit_en_d;
      ack_q      <= ack_d;
    end
  end

  // Owner code is a direct image of the arbiter state.
  always_comb begin
    case (state_q)
      ST_SHOW_CPU: disp_owner = OWN_CPU;
      ST_SHOW_SW:  disp_owner = OWN_SW;
      default:     disp_owner = OWN_NONE;
    endcase
  end

  disp_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .scan_tick (scan_tick),
    .digit_sel (digit_sel)
  );

  assign cpu_ack    = ack_q;
  assign disp_value = value_q;
  assign digit_en   = digit_en_q;

endmodule
